// File: rtl/turn_controller_pkg.sv
// Shared types and helpers for the chicken-race turn sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package turn_controller_pkg;

  localparam int PLAYER_W = 2;
  localparam int CARD_W   = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PICK,
    CMP_WAIT,
    ADV_WAIT,
    REVEAL,
    NEXT,
    DONE
  } state_t;

  // Largest of the three wait lengths; sizes the shared wait counter.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/turn_controller_if.sv
// Bundle between the keypad/card-select front end, data_path and the sequencer.
// Latency: n/a (wires only).
// Backpressure: none; picks are single-cycle pulses, dropped when not wanted.
interface turn_controller_if;
  import turn_controller_pkg::*;

  logic                start;
  logic [PLAYER_W-1:0] n_players;
  logic                pick_valid;
  logic [CARD_W-1:0]   pick_card;
  logic                same_result;
  logic                win_flag;

  logic [PLAYER_W-1:0] cur_player;
  logic [CARD_W-1:0]   card_out;
  logic                cmp_strobe;
  logic                advance;
  logic                turn_end;
  logic                reveal_on;
  logic                dup_pick;
  logic                winner_valid;
  logic [PLAYER_W-1:0] winner;

  // Front end / datapath side.
  modport master (
    output start, n_players, pick_valid, pick_card, same_result, win_flag,
    input  cur_player, card_out, cmp_strobe, advance, turn_end, reveal_on,
           dup_pick, winner_valid, winner
  );

  // Sequencer side.
  modport slave (
    input  start, n_players, pick_valid, pick_card, same_result, win_flag,
    output cur_player, card_out, cmp_strobe, advance, turn_end, reveal_on,
           dup_pick, winner_valid, winner
  );

endinterface

// File: rtl/turn_controller_wait_cnt.sv
// Load/decrement down counter with zero flag, shared by all sequencer waits.
// Latency: load visible next cycle; decrements once per cycle while dec is high.
// Backpressure: none; load has priority over dec, count saturates at zero.
module turn_wait_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load wins over decrement; stop at zero so a lingering dec is harmless.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/turn_controller.sv
// Game-sequencing FSM: accepts card picks, strobes compare, advances or reveals, rotates turns.
// Latency: cmp_strobe 1 cycle after an accepted pick; result sampled CMP_LAT cycles later.
// Backpressure: none; picks outside WAIT_PICK are dropped, bad picks get dup_pick.
module turn_controller
  import turn_controller_pkg::*;
#(
  parameter int NUM_CARDS   = 12,
  parameter int CMP_LAT     = 1,
  parameter int WIN_LAT     = 1,
  parameter int REVEAL_HOLD = 8
) (
  input logic             clk,
  input logic             rst_n,
  turn_controller_if.slave bus
);

  localparam int CNT_W  = $clog2(max3(CMP_LAT, WIN_LAT, REVEAL_HOLD) + 1);
  localparam int MASK_W = 1 << CARD_W;
  // Indices that do not name a real card read back as already taken.
  localparam logic [MASK_W-1:0] OUT_OF_RANGE = ~MASK_W'({NUM_CARDS{1'b1}});

  state_t              state;
  logic [PLAYER_W-1:0] last_player;
  logic [PLAYER_W-1:0] cur_player;
  logic [PLAYER_W-1:0] winner;
  logic [CARD_W-1:0]   card_out;
  logic                cmp_strobe;
  logic                advance;
  logic                turn_end;
  logic                reveal_on;
  logic                dup_pick;
  logic                winner_valid;
  logic [NUM_CARDS-1:0] mask;

  logic [MASK_W-1:0]   taken;
  logic                pick_taken;
  logic                mask_full;
  logic                accept;
  logic                cnt_load;
  logic                cnt_dec;
  logic                cnt_zero;
  logic [CNT_W-1:0]    cnt_val;

  assign taken      = OUT_OF_RANGE | MASK_W'(mask);
  assign pick_taken = taken[bus.pick_card];
  assign mask_full  = &mask;
  assign accept     = (state == WAIT_PICK) && !mask_full && bus.pick_valid && !pick_taken;

  // The reveal reload is one short so reveal_on lasts exactly REVEAL_HOLD cycles.
  always_comb begin
    cnt_load = 1'b0;
    cnt_val  = '0;
    cnt_dec  = (state == CMP_WAIT) || (state == ADV_WAIT) || (state == REVEAL);
    if (accept) begin
      cnt_load = 1'b1;
      cnt_val  = CNT_W'(CMP_LAT);
    end else if ((state == CMP_WAIT) && cnt_zero) begin
      cnt_load = 1'b1;
      cnt_val  = bus.same_result ? CNT_W'(WIN_LAT) : CNT_W'(REVEAL_HOLD - 1);
    end
  end

  turn_wait_cnt #(.W(CNT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Sequencer FSM; every output is a register, strobes default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_player  <= '0;
      cur_player   <= '0;
      winner       <= '0;
      card_out     <= '0;
      cmp_strobe   <= 1'b0;
      advance      <= 1'b0;
      turn_end     <= 1'b0;
      reveal_on    <= 1'b0;
      dup_pick     <= 1'b0;
      winner_valid <= 1'b0;
      mask         <= '0;
    end else begin
      cmp_strobe <= 1'b0;
      advance    <= 1'b0;
      turn_end   <= 1'b0;
      dup_pick   <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            // n_players of 0 still means a two-player game.
            last_player  <= (bus.n_players == '0) ? PLAYER_W'(1) : bus.n_players;
            cur_player   <= '0;
            winner_valid <= 1'b0;
            winner       <= '0;
            mask         <= '0;
            state        <= WAIT_PICK;
          end
        end
        WAIT_PICK: begin
          if (mask_full) begin
            // Nothing left to pick: hand the turn on without waiting.
            turn_end <= 1'b1;
            mask     <= '0;
            state    <= NEXT;
          end else if (bus.pick_valid) begin
            if (pick_taken) begin
              dup_pick <= 1'b1;
            end else begin
              card_out   <= bus.pick_card;
              mask       <= mask | (NUM_CARDS'(1) << bus.pick_card);
              cmp_strobe <= 1'b1;
              state      <= CMP_WAIT;
            end
          end
        end
        CMP_WAIT: begin
          if (cnt_zero) begin
            if (bus.same_result) begin
              advance <= 1'b1;
              state   <= ADV_WAIT;
            end else begin
              reveal_on <= 1'b1;
              state     <= REVEAL;
            end
          end
        end
        ADV_WAIT: begin
          if (cnt_zero) begin
            if (bus.win_flag) begin
              winner       <= cur_player;
              winner_valid <= 1'b1;
              state        <= DONE;
            end else begin
              state <= WAIT_PICK;
            end
          end
        end
        REVEAL: begin
          if (cnt_zero) begin
            reveal_on <= 1'b0;
            turn_end  <= 1'b1;
            mask      <= '0;
            state     <= NEXT;
          end
        end
        NEXT: begin
          cur_player <= (cur_player == last_player) ? '0 : cur_player + PLAYER_W'(1);
          state      <= WAIT_PICK;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cur_player   = cur_player;
  assign bus.card_out     = card_out;
  assign bus.cmp_strobe   = cmp_strobe;
  assign bus.advance      = advance;
  assign bus.turn_end     = turn_end;
  assign bus.reveal_on    = reveal_on;
  assign bus.dup_pick     = dup_pick;
  assign bus.winner_valid = winner_valid;
  assign bus.winner       = winner;

endmodule
